// File: rtl/apb_master_mp_if.sv
// Command/response handshake and APB3 completer-side signals of apb_master_mp.
// prdata is flattened: slave i drives [i*DATA_W +: DATA_W].
interface apb_master_mp_if #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4
);
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic                         cmd_wr;
  logic [ADDR_W-1:0]            cmd_addr;
  logic [DATA_W-1:0]            cmd_wdata;
  logic [DATA_W/8-1:0]          cmd_strb;

  logic                         rsp_valid;
  logic [DATA_W-1:0]            rsp_rdata;
  logic                         rsp_err;
  logic                         rsp_timeout;

  logic [NUM_SLAVES-1:0]        psel;
  logic                         penable;
  logic                         pwrite;
  logic [ADDR_W-1:0]            paddr;
  logic [DATA_W-1:0]            pwdata;
  logic [DATA_W/8-1:0]          pstrb;
  logic [NUM_SLAVES-1:0]        pready;
  logic [NUM_SLAVES*DATA_W-1:0] prdata;
  logic [NUM_SLAVES-1:0]        pslverr;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_strb,
    input  pready, prdata, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata, pstrb
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_strb,
    output pready, prdata, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata, pstrb
  );
endinterface

// File: rtl/apb_master_mp.sv
// APB3 requester: one accepted command -> SETUP + ACCESS on one of NUM_SLAVES completers; response pulse
// 2 cycles after accept with no wait states. cmd_ready is high only in IDLE, so commands are never queued.
module apb_master_mp #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter int TIMEOUT    = 16
) (
  input logic             clk,
  input logic             rst,
  apb_master_mp_if.master bus
);
  localparam int SEL_W  = $clog2(NUM_SLAVES);
  localparam int SEL_W1 = SEL_W + 1;
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SEL_W:0]   NS_LIM   = SEL_W1'(NUM_SLAVES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DERR} state_t;

  state_t                state_q, state_nxt;
  logic [SEL_W-1:0]      sel_q, sel_nxt;
  logic [CNT_W-1:0]      cnt_q, cnt_nxt;
  logic [NUM_SLAVES-1:0] psel_q, psel_nxt;
  logic                  penable_q, penable_nxt;
  logic                  pwrite_q, pwrite_nxt;
  logic [ADDR_W-1:0]     paddr_q, paddr_nxt;
  logic [DATA_W-1:0]     pwdata_q, pwdata_nxt;
  logic [STRB_W-1:0]     pstrb_q, pstrb_nxt;
  logic                  rsp_valid_q, rsp_valid_nxt;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_nxt;
  logic                  rsp_err_q, rsp_err_nxt;
  logic                  rsp_timeout_q, rsp_timeout_nxt;

  logic [SEL_W-1:0]      cmd_idx;
  logic                  sel_rdy;
  logic                  sel_err;
  logic [DATA_W-1:0]     sel_rdata;

  assign cmd_idx   = bus.cmd_addr[ADDR_W-1 -: SEL_W];
  assign sel_rdy   = bus.pready[sel_q];
  assign sel_err   = bus.pslverr[sel_q];
  assign sel_rdata = bus.prdata[sel_q*DATA_W +: DATA_W];

  always_comb begin
    state_nxt       = state_q;
    sel_nxt         = sel_q;
    cnt_nxt         = cnt_q;
    psel_nxt        = psel_q;
    penable_nxt     = penable_q;
    pwrite_nxt      = pwrite_q;
    paddr_nxt       = paddr_q;
    pwdata_nxt      = pwdata_q;
    pstrb_nxt       = pstrb_q;
    rsp_valid_nxt   = 1'b0;
    rsp_rdata_nxt   = rsp_rdata_q;
    rsp_err_nxt     = rsp_err_q;
    rsp_timeout_nxt = rsp_timeout_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          sel_nxt = cmd_idx;
          // Out-of-range selects never touch the bus; they answer from DERR.
          if ({1'b0, cmd_idx} < NS_LIM) begin
            state_nxt   = SETUP;
            psel_nxt    = NUM_SLAVES'(1) << cmd_idx;
            penable_nxt = 1'b0;
            paddr_nxt   = bus.cmd_addr;
            pwrite_nxt  = bus.cmd_wr;
            pwdata_nxt  = bus.cmd_wdata;
            pstrb_nxt   = bus.cmd_wr ? bus.cmd_strb : '0;
          end else begin
            state_nxt = DERR;
          end
        end
      end
      SETUP: begin
        state_nxt   = ACCESS;
        penable_nxt = 1'b1;
        cnt_nxt     = '0;
      end
      ACCESS: begin
        if (sel_rdy) begin
          state_nxt       = IDLE;
          psel_nxt        = '0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = sel_err;
          rsp_timeout_nxt = 1'b0;
          rsp_rdata_nxt   = (!pwrite_q && !sel_err) ? sel_rdata : '0;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_nxt       = IDLE;
          psel_nxt        = '0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = 1'b1;
          rsp_timeout_nxt = 1'b1;
          rsp_rdata_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      DERR: begin
        state_nxt       = IDLE;
        rsp_valid_nxt   = 1'b1;
        rsp_err_nxt     = 1'b1;
        rsp_timeout_nxt = 1'b0;
        rsp_rdata_nxt   = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      cnt_q         <= '0;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      sel_q         <= sel_nxt;
      cnt_q         <= cnt_nxt;
      psel_q        <= psel_nxt;
      penable_q     <= penable_nxt;
      pwrite_q      <= pwrite_nxt;
      paddr_q       <= paddr_nxt;
      pwdata_q      <= pwdata_nxt;
      pstrb_q       <= pstrb_nxt;
      rsp_valid_q   <= rsp_valid_nxt;
      rsp_rdata_q   <= rsp_rdata_nxt;
      rsp_err_q     <= rsp_err_nxt;
      rsp_timeout_q <= rsp_timeout_nxt;
    end
  end

  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.pstrb       = pstrb_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_master_mp.sv
// Bench for apb_master_mp: directed and random transfers against a wait-count/timeout model,
// plus a 3-slave instance for the decode-error path.
module tb_apb_master_mp;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int TO = 16;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_master_mp_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(NS)) bus ();
  apb_master_mp #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(NS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  apb_master_mp_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(3)) bus3 ();
  apb_master_mp #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(3), .TIMEOUT(4)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Unselected slaves get random noise; the selected one gets the controlled values.
  task automatic drive_slaves(input int idx, input bit rdy, input bit err, input logic [DW-1:0] rd);
    for (int i = 0; i < NS; i++) begin
      bus.pready[i]            = 1'($urandom_range(0, 1));
      bus.pslverr[i]           = 1'($urandom_range(0, 1));
      bus.prdata[i*DW +: DW]   = $urandom;
    end
    bus.pready[idx]          = rdy;
    bus.pslverr[idx]         = err;
    bus.prdata[idx*DW +: DW] = rd;
  endtask

  // Selected slave raises pready after 'waits' ACCESS cycles; reference outcome is plain arithmetic.
  task automatic do_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [SW-1:0] st, input int waits, input bit err,
                        input logic [DW-1:0] rd);
    int             idx;
    logic [NS-1:0]  oh;
    int             exp_acc;
    bit             exp_to;
    bit             exp_err;
    logic [DW-1:0]  exp_rd;
    logic [SW-1:0]  exp_st;
    int             acc;
    idx     = int'(addr[AW-1 -: 2]);
    oh      = NS'(1) << idx;
    exp_to  = (waits >= TO);
    exp_acc = exp_to ? TO : waits + 1;
    exp_err = exp_to || err;
    exp_rd  = (!wr && !exp_err) ? rd : '0;
    exp_st  = wr ? st : '0;
    acc     = 0;

    @(negedge clk);
    chk_eq("cmd_ready_idle", 64'(bus.cmd_ready), 64'(1));
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    bus.cmd_strb  = st;
    drive_slaves(idx, 1'b0, err, rd);
    @(negedge clk);
    // Keep offering garbage commands: they must be ignored until the response.
    bus.cmd_wr    = 1'($urandom_range(0, 1));
    bus.cmd_addr  = AW'($urandom);
    bus.cmd_wdata = $urandom;
    bus.cmd_strb  = SW'($urandom);
    chk_eq("setup_psel", 64'(bus.psel), 64'(oh));
    chk_eq("setup_penable", 64'(bus.penable), 64'(0));
    chk_eq("setup_paddr", 64'(bus.paddr), 64'(addr));
    chk_eq("setup_pwrite", 64'(bus.pwrite), 64'(wr));
    chk_eq("setup_pwdata", 64'(bus.pwdata), 64'(wd));
    chk_eq("setup_pstrb", 64'(bus.pstrb), 64'(exp_st));
    chk_eq("setup_cmd_ready", 64'(bus.cmd_ready), 64'(0));
    drive_slaves(idx, 1'b0, err, rd);
    @(negedge clk);
    for (int c = 0; c < TO + 4; c++) begin
      if (bus.rsp_valid) break;
      chk_eq("access_penable", 64'(bus.penable), 64'(1));
      chk_eq("access_psel", 64'(bus.psel), 64'(oh));
      chk_eq("access_paddr", 64'(bus.paddr), 64'(addr));
      chk_eq("access_pstrb", 64'(bus.pstrb), 64'(exp_st));
      acc++;
      drive_slaves(idx, acc > waits, err, rd);
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    chk_eq("rsp_valid", 64'(bus.rsp_valid), 64'(1));
    chk_eq("access_cycles", 64'(acc), 64'(exp_acc));
    chk_eq("rsp_err", 64'(bus.rsp_err), 64'(exp_err));
    chk_eq("rsp_timeout", 64'(bus.rsp_timeout), 64'(exp_to));
    chk_eq("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_rd));
    chk_eq("done_psel", 64'(bus.psel), 64'(0));
    chk_eq("done_penable", 64'(bus.penable), 64'(0));
    chk_eq("done_paddr_held", 64'(bus.paddr), 64'(addr));
    chk_eq("done_pwdata_held", 64'(bus.pwdata), 64'(wd));
    chk_eq("done_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    @(negedge clk);
    chk_eq("rsp_valid_pulse", 64'(bus.rsp_valid), 64'(0));
    chk_eq("rsp_rdata_hold", 64'(bus.rsp_rdata), 64'(exp_rd));
    chk_eq("rsp_err_hold", 64'(bus.rsp_err), 64'(exp_err));
  endtask

  initial begin
    rst = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_wr = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0; bus.cmd_strb = '0;
    bus.pready = '0; bus.pslverr = '0; bus.prdata = '0;
    bus3.cmd_valid = 1'b0; bus3.cmd_wr = 1'b0; bus3.cmd_addr = '0; bus3.cmd_wdata = '0;
    bus3.cmd_strb = '0; bus3.pready = '1; bus3.pslverr = '0;
    bus3.prdata = {32'h77665544, 32'h22222222, 32'h11111111};
    repeat (3) @(negedge clk);
    chk_eq("rst_psel", 64'(bus.psel), 64'(0));
    chk_eq("rst_penable", 64'(bus.penable), 64'(0));
    chk_eq("rst_paddr", 64'(bus.paddr), 64'(0));
    chk_eq("rst_pstrb", 64'(bus.pstrb), 64'(0));
    chk_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk_eq("rst_rsp_err", 64'(bus.rsp_err), 64'(0));
    chk_eq("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
    chk_eq("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    rst = 1'b1;

    do_txn(1'b1, 8'h45, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0);
    do_txn(1'b0, 8'hC8, 32'h0, 4'hF, 3, 1'b0, 32'h12345678);
    do_txn(1'b0, 8'h80, 32'h0, 4'h0, 0, 1'b1, 32'hA5A5A5A5);
    do_txn(1'b0, 8'h10, 32'h0, 4'h0, 40, 1'b0, 32'h1);
    do_txn(1'b0, 8'h3C, 32'h0, 4'h3, 15, 1'b0, 32'h0F0F0F0F);
    do_txn(1'b1, 8'hFF, 32'h55AA55AA, 4'h5, 16, 1'b0, 32'h0);

    for (int n = 0; n < 40; n++) begin
      int r;
      int w;
      r = int'($urandom_range(0, 9));
      w = (r == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 4));
      do_txn(1'($urandom_range(0, 1)), AW'($urandom), $urandom, SW'($urandom), w,
             ($urandom_range(0, 3) == 0), $urandom);
    end

    // Reset in the middle of an ACCESS: bus must drop asynchronously with no response.
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b0; bus.cmd_addr = 8'h40;
    drive_slaves(1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    drive_slaves(1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    drive_slaves(1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk_eq("pre_rst_penable", 64'(bus.penable), 64'(1));
    #2 rst = 1'b0;
    #1;
    chk_eq("async_rst_psel", 64'(bus.psel), 64'(0));
    chk_eq("async_rst_penable", 64'(bus.penable), 64'(0));
    chk_eq("async_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    bus.pready = '1;
    repeat (2) begin
      @(negedge clk);
      chk_eq("in_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    end
    rst = 1'b1;
    do_txn(1'b0, 8'h40, 32'h0, 4'h0, 1, 1'b0, 32'hCAFEF00D);

    // Three-slave instance: select 3 is a decode error, select 2 is a normal read.
    @(negedge clk);
    chk_eq("d3_cmd_ready", 64'(bus3.cmd_ready), 64'(1));
    bus3.cmd_valid = 1'b1; bus3.cmd_wr = 1'b1; bus3.cmd_addr = 8'hC0;
    bus3.cmd_wdata = 32'h01020304; bus3.cmd_strb = 4'hF;
    @(negedge clk);
    bus3.cmd_valid = 1'b0;
    chk_eq("d3_derr_psel", 64'(bus3.psel), 64'(0));
    chk_eq("d3_derr_rsp_early", 64'(bus3.rsp_valid), 64'(0));
    chk_eq("d3_derr_cmd_ready", 64'(bus3.cmd_ready), 64'(0));
    @(negedge clk);
    chk_eq("d3_derr_rsp_valid", 64'(bus3.rsp_valid), 64'(1));
    chk_eq("d3_derr_rsp_err", 64'(bus3.rsp_err), 64'(1));
    chk_eq("d3_derr_rsp_timeout", 64'(bus3.rsp_timeout), 64'(0));
    chk_eq("d3_derr_rsp_rdata", 64'(bus3.rsp_rdata), 64'(0));
    chk_eq("d3_derr_psel_after", 64'(bus3.psel), 64'(0));
    @(negedge clk);
    chk_eq("d3_derr_pulse", 64'(bus3.rsp_valid), 64'(0));
    bus3.cmd_valid = 1'b1; bus3.cmd_wr = 1'b0; bus3.cmd_addr = 8'h80;
    @(negedge clk);
    bus3.cmd_valid = 1'b0;
    chk_eq("d3_rd_psel", 64'(bus3.psel), 64'(3'b100));
    @(negedge clk);
    chk_eq("d3_rd_penable", 64'(bus3.penable), 64'(1));
    @(negedge clk);
    chk_eq("d3_rd_rsp_valid", 64'(bus3.rsp_valid), 64'(1));
    chk_eq("d3_rd_rsp_err", 64'(bus3.rsp_err), 64'(0));
    chk_eq("d3_rd_rsp_rdata", 64'(bus3.rsp_rdata), 64'(32'h77665544));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/apb_master_mp.md
Name: apb_master_mp

Overview:
- Parametrised APB3 requester; successor to the fixed 8-bit/32-bit, 4-port APB master.
- Accepts single commands on a valid/ready interface and runs one APB transfer (SETUP, then ACCESS) to one of NUM_SLAVES completers, decoded from the top address bits.
- Honours PREADY wait states and PSLVERR, and aborts hung transfers with a timeout.
- Returns read data and status on a one-cycle response strobe. Sits between the bus-bridge command logic and the peripheral APB segment.

Parameters:
- ADDR_W, 8, address width in bits; must be at least SEL_W+2.
- DATA_W, 32, data width in bits; 8, 16 or 32.
- NUM_SLAVES, 4, number of completers; 2..16.
- TIMEOUT, 16, maximum ACCESS cycles before abort; 0 disables the timeout.
- Derived (not a parameter): SEL_W = clog2(NUM_SLAVES).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_wr  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  byte address; [ADDR_W-1 -: SEL_W] selects the slave.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  DATA_W/8  write byte strobes.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  PSLVERR, decode error or timeout.
- rsp_timeout  out  1  error caused by timeout.
- psel  out  NUM_SLAVES  one-hot select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- pstrb  out  DATA_W/8  APB strobes.
- pready  in  NUM_SLAVES  per-slave ready.
- prdata  in  NUM_SLAVES*DATA_W  flattened read data; slave i occupies [i*DATA_W +: DATA_W].
- pslverr  in  NUM_SLAVES  per-slave error.

Behaviour:
- All outputs are registered except cmd_ready, which is high exactly when state==IDLE.
- Reset (rst low, asynchronous):
  - state=IDLE, timeout counter=0.
  - psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_err, rsp_timeout all 0.
  - Reset mid-transfer drops psel/penable immediately and produces no response.
- State machine: IDLE, SETUP, ACCESS, DERR.
- IDLE, on accept (cmd_valid and cmd_ready):
  - Latch the command.
  - idx < NUM_SLAVES: go to SETUP with psel[idx]=1, penable=0, paddr=cmd_addr, pwrite=cmd_wr, pwdata=cmd_wdata, pstrb=cmd_wr?cmd_strb:0.
  - idx >= NUM_SLAVES: go to DERR; no bus activity.
- SETUP: lasts exactly one cycle. Set penable=1 and go to ACCESS; clear the counter.
- ACCESS:
  - paddr, pwrite, pwdata, pstrb and psel are held stable.
  - pready[idx]=1: complete. psel=0, penable=0, rsp_valid=1, rsp_err=pslverr[idx], rsp_timeout=0. rsp_rdata=prdata slice idx for an error-free read, else 0. Go to IDLE.
  - pready[idx]=0 and TIMEOUT!=0 and counter==TIMEOUT-1: abort. psel=0, penable=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0. Go to IDLE.
  - Otherwise increment the counter.
  - pready and pslverr of unselected slaves are ignored.
- DERR: lasts one cycle. rsp_valid=1, rsp_err=1, rsp_timeout=0, rsp_rdata=0; go to IDLE.
- rsp_valid is high for exactly one cycle. rsp_rdata and rsp_err hold their value until the next response.
- After completion, paddr, pwrite, pwdata and pstrb keep their last value; psel and penable are 0.
- Latency with no wait states: accept at edge k, SETUP after k, ACCESS after k+1, rsp_valid and cmd_ready high after k+2. Minimum 3 cycles per transfer.
- An ACCESS lasts at most TIMEOUT cycles.
- No command queueing: while state != IDLE, cmd_valid is ignored.

Test Plan:
- Write, addr 0x45, wdata 0xDEADBEEF, strb 0xF, slave 1 pready=1 -> psel=0b0010. SETUP one cycle with penable=0, then ACCESS with penable=1. rsp_valid 2 cycles after accept; rsp_err=0, rsp_rdata=0.
- Read, addr 0xC8, slave 3 holds pready=0 for 3 ACCESS cycles then returns prdata=0x12345678 -> ACCESS lasts 4 cycles with paddr=0xC8 stable throughout. rsp_rdata=0x12345678; pstrb=0 during the transfer.
- Read to slave 2 with pslverr=1 and pready=1 -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- TIMEOUT=16, pready stuck at 0 -> penable high for exactly 16 cycles, then psel=0, rsp_err=1, rsp_timeout=1.
- NUM_SLAVES=3, ADDR_W=8, addr 0xC0 -> psel never asserts; rsp_valid one cycle after accept with rsp_err=1.
- rst pulled low during ACCESS -> psel and penable drop without waiting for clk, no rsp_valid. The next command after reset release completes normally.
